i2s_rx_src_ctrl: RTL and testbench
==================================

I2S_RX_SRC_CTRL -- requirements
Module: i2s_rx_src_ctrl

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 64, SHALL set the maximum DRAIN-state cycles before a forced exit.
REQ-002 clk_i  in  1  SHALL be the single clock; all logic is synchronous to its rising edge.
REQ-003 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-004 cfg_slave_en_i  in  1  SHALL be the receive-path enable request.
REQ-005 cfg_mode_i  in  2  SHALL be the requested source: 0 = I2S, 1 = DSP, 2 = PDM, 3 = reserved.
REQ-006 cfg_guard_cycles_i  in  8  SHALL be the number of all-disabled cycles required between sources.
REQ-007 en_i2s_o, en_dsp_o, en_pdm_o  out  1 each  SHALL be the receiver enables; they are one-hot or all zero.
REQ-008 i2s_data_i / dsp_data_i  in  32, pdm_data_i  in  16, with {src}_valid_i in 1 and {src}_ready_o out 1, SHALL be the three source streams.
REQ-009 fifo_rx_data_o  out  32, fifo_rx_data_valid_o  out  1, fifo_rx_data_ready_i  in  1  SHALL be the merged output stream.
REQ-010 busy_o  out  1, active_mode_o  out  2, err_o  out  1  SHALL be the status outputs.

Function
REQ-011 FSM states SHALL be IDLE, ACTIVE, DRAIN and GUARD.
REQ-012 IDLE: all enables low; on cfg_slave_en_i=1 with mode≠3, latch the mode into active_mode_o and go to ACTIVE.
REQ-013 IDLE with cfg_slave_en_i=1 and mode=3: stay in IDLE and set sticky err_o; err_o clears on the first cycle with cfg_slave_en_i=0.
REQ-014 ACTIVE: the enable selected by the latched mode SHALL be high from the cycle after entry.
REQ-015 ACTIVE: if cfg_slave_en_i=0 or cfg_mode_i≠latched mode, go to DRAIN; the enable drops in the same registered update.
REQ-016 DRAIN: keep forwarding the latched source; go to GUARD when its valid is low and the output register is empty, or after DRAIN_TIMEOUT cycles.
REQ-017 A DRAIN exit by timeout SHALL set err_o (sticky, cleared as in REQ-013).
REQ-018 GUARD: count cfg_guard_cycles_i cycles with all enables low, then go to IDLE; a value of 0 SHALL take exactly one cycle.
REQ-019 Output path: a one-entry register with a latency of 1 cycle from source handshake to fifo_rx_data_valid_o.
REQ-020 Selected source ready = !out_valid | fifo_rx_data_ready_i, in ACTIVE and DRAIN only.
REQ-021 Non-selected sources SHALL see ready=0 at all times; ready SHALL be 0 for all sources in IDLE and GUARD.
REQ-022 PDM data SHALL be zero-extended to 32 bits: {16'h0, pdm_data_i}.
REQ-023 Once fifo_rx_data_valid_o is high, it and the data SHALL hold stable until fifo_rx_data_ready_i is high.
REQ-024 A source beat accepted in the same cycle as a config change SHALL complete and be delivered.
REQ-025 busy_o SHALL be high in every state except IDLE.

Reset
REQ-026 On rst_i, the state SHALL go to IDLE and all enables, valid, ready, busy_o and err_o SHALL be 0.
REQ-027 On rst_i, fifo_rx_data_o and active_mode_o SHALL be 0.
REQ-028 Reset mid-transfer SHALL discard the output register contents; no beat is emitted after reset.

Structure
REQ-029 Package i2s_rx_ctrl_pkg SHALL hold the mode enum (I2S/DSP/PDM/RSVD), the state enum and the DRAIN_TIMEOUT default.
REQ-030 The block SHALL be a single module with no sub-module; the output register and counters are inline.

Verification
REQ-031 Scenario 1: en=1, mode=0, i2s beats 0xA5A5_0001..0004 -> en_i2s_o high, 4 beats out in order with 1-cycle latency.
REQ-032 Scenario 2: mode=2, pdm 0x1234 -> output 0x0000_1234; dsp/i2s ready stay 0.
REQ-033 Scenario 3: ACTIVE I2S, switch to mode=1 with guard=5 and one beat pending -> beat delivered, then ≥5 cycles with all enables low, then en_dsp_o high.
REQ-034 Scenario 4: drain with i2s_valid stuck high and fifo_ready=0 -> GUARD entered after 64 cycles and err_o=1.
REQ-035 Scenario 5: mode=3, en=1 -> enables stay 0 and err_o=1; en=0 -> err_o=0.
REQ-036 Scenario 6: rst_i pulsed while valid_o=1 and ready=0 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/i2s_rx_ctrl_pkg.sv
// Shared types for the I2S/DSP/PDM receive source controller: source modes,
// controller states and the default drain timeout.
package i2s_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_I2S  = 2'd0,
    MODE_DSP  = 2'd1,
    MODE_PDM  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GUARD  = 2'd3
  } state_e;

  localparam int unsigned DRAIN_TIMEOUT_DEF = 32'd64;

endpackage

// File: rtl/i2s_rx_src_ctrl.sv
// Receive source controller: selects one of three audio sources, merges it into
// a single output stream and enforces a drain + all-off guard gap between sources.
module i2s_rx_src_ctrl
  import i2s_rx_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_slave_en_i,
  input  logic [1:0]  cfg_mode_i,
  input  logic [7:0]  cfg_guard_cycles_i,
  output logic        en_i2s_o,
  output logic        en_dsp_o,
  output logic        en_pdm_o,
  input  logic [31:0] i2s_data_i,
  input  logic        i2s_valid_i,
  output logic        i2s_ready_o,
  input  logic [31:0] dsp_data_i,
  input  logic        dsp_valid_i,
  output logic        dsp_ready_o,
  input  logic [15:0] pdm_data_i,
  input  logic        pdm_valid_i,
  output logic        pdm_ready_o,
  output logic [31:0] fifo_rx_data_o,
  output logic        fifo_rx_data_valid_o,
  input  logic        fifo_rx_data_ready_i,
  output logic        busy_o,
  output logic [1:0]  active_mode_o,
  output logic        err_o
);

  localparam logic [1:0]  S_IDLE      = ST_IDLE;
  localparam logic [1:0]  S_ACTIVE    = ST_ACTIVE;
  localparam logic [1:0]  S_DRAIN     = ST_DRAIN;
  localparam logic [1:0]  S_GUARD     = ST_GUARD;
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [2:0]  en_q, en_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;

  logic        err_set_s;
  logic        sel_valid_s;
  logic [31:0] sel_data_s;
  logic        ready_s;
  logic        accept_s;

  // Source selection follows the latched mode, never the live request.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = 32'h0000_0000;
    case (mode_q)
      MODE_I2S: begin
        sel_valid_s = i2s_valid_i;
        sel_data_s  = i2s_data_i;
      end
      MODE_DSP: begin
        sel_valid_s = dsp_valid_i;
        sel_data_s  = dsp_data_i;
      end
      MODE_PDM: begin
        sel_valid_s = pdm_valid_i;
        sel_data_s  = {16'h0000, pdm_data_i};
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_data_s  = 32'h0000_0000;
      end
    endcase
  end

  assign ready_s  = !rst_i && (state_q == S_ACTIVE || state_q == S_DRAIN) &&
                    (!out_valid_q || fifo_rx_data_ready_i);
  assign accept_s = ready_s && sel_valid_s;

  assign i2s_ready_o = ready_s && (mode_q == MODE_I2S);
  assign dsp_ready_o = ready_s && (mode_q == MODE_DSP);
  assign pdm_ready_o = ready_s && (mode_q == MODE_PDM);

  // Controller next state, drain/guard counters and sticky error.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    drain_cnt_d = drain_cnt_q;
    guard_cnt_d = guard_cnt_q;
    err_set_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_slave_en_i) begin
          if (cfg_mode_i == MODE_RSVD) begin
            err_set_s = 1'b1;
          end else begin
            mode_d  = cfg_mode_i;
            state_d = S_ACTIVE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!cfg_slave_en_i || (cfg_mode_i != mode_q)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 16'd0;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        if (!sel_valid_s && !out_valid_q) begin
          state_d     = S_GUARD;
          guard_cnt_d = 8'd0;
        end else if (drain_cnt_q >= DRAIN_LAST) begin
          state_d     = S_GUARD;
          guard_cnt_d = 8'd0;
          err_set_s   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 16'd1;
        end
      end
      S_GUARD: begin
        // A guard value of zero still spends one cycle here.
        if (({1'b0, guard_cnt_q} + 9'd1) >= {1'b0, cfg_guard_cycles_i}) begin
          state_d = S_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (err_set_s) begin
      err_d = 1'b1;
    end else if (!cfg_slave_en_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    busy_d = (state_d != S_IDLE);
    if (state_d == S_ACTIVE) begin
      en_d = {(mode_d == MODE_I2S), (mode_d == MODE_DSP), (mode_d == MODE_PDM)};
    end else begin
      en_d = 3'b000;
    end
  end

  // One-entry output register: load on source handshake, empty on sink handshake.
  always_comb begin
    out_data_d = out_data_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
    end else if (fifo_rx_data_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 3'b000;
      drain_cnt_q <= 16'd0;
      guard_cnt_q <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      drain_cnt_q <= drain_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign en_i2s_o             = en_q[2];
  assign en_dsp_o             = en_q[1];
  assign en_pdm_o             = en_q[0];
  assign fifo_rx_data_o       = out_data_q;
  assign fifo_rx_data_valid_o = out_valid_q;
  assign busy_o               = busy_q;
  assign active_mode_o        = mode_q;
  assign err_o                = err_q;

endmodule

// File: tb/tb_i2s_rx_src_ctrl.sv
// Directed self-checking bench for i2s_rx_src_ctrl.
module tb_i2s_rx_src_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_slave_en_i;
  logic [1:0]  cfg_mode_i;
  logic [7:0]  cfg_guard_cycles_i;
  logic        en_i2s_o, en_dsp_o, en_pdm_o;
  logic [31:0] i2s_data_i, dsp_data_i;
  logic [15:0] pdm_data_i;
  logic        i2s_valid_i, dsp_valid_i, pdm_valid_i;
  logic        i2s_ready_o, dsp_ready_o, pdm_ready_o;
  logic [31:0] fifo_rx_data_o;
  logic        fifo_rx_data_valid_o;
  logic        fifo_rx_data_ready_i;
  logic        busy_o;
  logic [1:0]  active_mode_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  i2s_rx_src_ctrl dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .cfg_slave_en_i       (cfg_slave_en_i),
    .cfg_mode_i           (cfg_mode_i),
    .cfg_guard_cycles_i   (cfg_guard_cycles_i),
    .en_i2s_o             (en_i2s_o),
    .en_dsp_o             (en_dsp_o),
    .en_pdm_o             (en_pdm_o),
    .i2s_data_i           (i2s_data_i),
    .i2s_valid_i          (i2s_valid_i),
    .i2s_ready_o          (i2s_ready_o),
    .dsp_data_i           (dsp_data_i),
    .dsp_valid_i          (dsp_valid_i),
    .dsp_ready_o          (dsp_ready_o),
    .pdm_data_i           (pdm_data_i),
    .pdm_valid_i          (pdm_valid_i),
    .pdm_ready_o          (pdm_ready_o),
    .fifo_rx_data_o       (fifo_rx_data_o),
    .fifo_rx_data_valid_o (fifo_rx_data_valid_o),
    .fifo_rx_data_ready_i (fifo_rx_data_ready_i),
    .busy_o               (busy_o),
    .active_mode_o        (active_mode_o),
    .err_o                (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_en(input logic [2:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ({en_i2s_o, en_dsp_o, en_pdm_o} === want) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    rst_i = 1'b1;
    tick();
    tick();
    flags = {en_i2s_o, en_dsp_o, en_pdm_o, fifo_rx_data_valid_o, busy_o, err_o,
             i2s_ready_o, dsp_ready_o, pdm_ready_o};
    checks++;
    if (flags !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", flags, 9'b0);
    end
    checks++;
    if (fifo_rx_data_o !== 32'h0 || active_mode_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_data_mode: got data %h mode %0d expected 0/0", fifo_rx_data_o, active_mode_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_i2s_stream();
    logic [31:0] exp;
    fifo_rx_data_ready_i = 1'b1;
    cfg_mode_i = 2'd0;
    cfg_guard_cycles_i = 8'd0;
    cfg_slave_en_i = 1'b1;
    tick();
    checks++;
    if ({en_i2s_o, en_dsp_o, en_pdm_o, busy_o} !== 4'b1001 || active_mode_o !== 2'd0) begin
      errors++;
      $display("FAIL i2s_enable: got en %b busy %b mode %0d expected 100/1/0",
               {en_i2s_o, en_dsp_o, en_pdm_o}, busy_o, active_mode_o);
    end
    for (int k = 1; k <= 4; k++) begin
      exp = 32'hA5A5_0000 + 32'(k);
      i2s_data_i = exp;
      i2s_valid_i = 1'b1;
      #1;
      checks++;
      if ({i2s_ready_o, dsp_ready_o, pdm_ready_o} !== 3'b100) begin
        errors++;
        $display("FAIL i2s_ready_%0d: got %b expected 100", k, {i2s_ready_o, dsp_ready_o, pdm_ready_o});
      end
      tick();
      checks++;
      if (fifo_rx_data_valid_o !== 1'b1 || fifo_rx_data_o !== exp) begin
        errors++;
        $display("FAIL i2s_beat_%0d: got v=%b %h expected v=1 %h", k, fifo_rx_data_valid_o, fifo_rx_data_o, exp);
      end
    end
    i2s_valid_i = 1'b0;
    tick();
    checks++;
    if (fifo_rx_data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL i2s_drained: got valid %b expected 0", fifo_rx_data_valid_o);
    end
  endtask

  task automatic test_pdm_zero_ext();
    bit ok;
    cfg_mode_i = 2'd2;
    wait_en(3'b001, ok);
    checks++;
    if (!ok || active_mode_o !== 2'd2) begin
      errors++;
      $display("FAIL pdm_enable: got en %b mode %0d expected 001/2",
               {en_i2s_o, en_dsp_o, en_pdm_o}, active_mode_o);
    end
    pdm_data_i = 16'h1234;
    pdm_valid_i = 1'b1;
    i2s_valid_i = 1'b1;
    dsp_valid_i = 1'b1;
    #1;
    checks++;
    if ({i2s_ready_o, dsp_ready_o, pdm_ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL pdm_ready: got %b expected 001", {i2s_ready_o, dsp_ready_o, pdm_ready_o});
    end
    tick();
    pdm_valid_i = 1'b0;
    i2s_valid_i = 1'b0;
    dsp_valid_i = 1'b0;
    checks++;
    if (fifo_rx_data_valid_o !== 1'b1 || fifo_rx_data_o !== 32'h0000_1234) begin
      errors++;
      $display("FAIL pdm_zero_ext: got v=%b %h expected v=1 00001234", fifo_rx_data_valid_o, fifo_rx_data_o);
    end
    tick();
  endtask

  task automatic test_mode_switch();
    bit ok;
    int lowcnt;
    cfg_mode_i = 2'd0;
    cfg_guard_cycles_i = 8'd0;
    wait_en(3'b100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL switch_setup: got en %b expected 100", {en_i2s_o, en_dsp_o, en_pdm_o});
    end
    fifo_rx_data_ready_i = 1'b0;
    i2s_data_i = 32'hDEAD_BEEF;
    i2s_valid_i = 1'b1;
    cfg_mode_i = 2'd1;
    cfg_guard_cycles_i = 8'd5;
    tick();
    i2s_valid_i = 1'b0;
    lowcnt = ({en_i2s_o, en_dsp_o, en_pdm_o} == 3'b000) ? 1 : 0;
    checks++;
    if (fifo_rx_data_valid_o !== 1'b1 || fifo_rx_data_o !== 32'hDEAD_BEEF || en_i2s_o !== 1'b0) begin
      errors++;
      $display("FAIL switch_pending_beat: got v=%b %h en_i2s=%b expected v=1 deadbeef en_i2s=0",
               fifo_rx_data_valid_o, fifo_rx_data_o, en_i2s_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({en_i2s_o, en_dsp_o, en_pdm_o} == 3'b000) lowcnt++;
      checks++;
      if (fifo_rx_data_valid_o !== 1'b1 || fifo_rx_data_o !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL hold_stable_%0d: got v=%b %h expected v=1 deadbeef", i, fifo_rx_data_valid_o, fifo_rx_data_o);
      end
    end
    fifo_rx_data_ready_i = 1'b1;
    tick();
    if ({en_i2s_o, en_dsp_o, en_pdm_o} == 3'b000) lowcnt++;
    checks++;
    if (fifo_rx_data_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL switch_delivered: got valid %b expected 0", fifo_rx_data_valid_o);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (en_dsp_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if ({en_i2s_o, en_dsp_o, en_pdm_o} == 3'b000) lowcnt++;
    end
    checks++;
    if (!ok || lowcnt != 10 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL guard_gap: got dsp_en=%b low_cycles=%0d err=%b expected 1/10/0", ok, lowcnt, err_o);
    end
  endtask

  task automatic test_drain_timeout();
    bit ok;
    int n;
    cfg_mode_i = 2'd0;
    cfg_guard_cycles_i = 8'd0;
    fifo_rx_data_ready_i = 1'b1;
    wait_en(3'b100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_setup: got en %b expected 100", {en_i2s_o, en_dsp_o, en_pdm_o});
    end
    fifo_rx_data_ready_i = 1'b0;
    i2s_data_i = 32'hCAFE_0001;
    i2s_valid_i = 1'b1;
    tick();
    cfg_mode_i = 2'd1;
    tick();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (err_o === 1'b1) break;
    end
    checks++;
    if (n != 64 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles err=%b expected 64/1", n, err_o);
    end
    checks++;
    if (i2s_ready_o !== 1'b0 || fifo_rx_data_valid_o !== 1'b1 || fifo_rx_data_o !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL timeout_hold: got rdy=%b v=%b %h expected 0/1 cafe0001",
               i2s_ready_o, fifo_rx_data_valid_o, fifo_rx_data_o);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err_o);
    end
    i2s_valid_i = 1'b0;
    fifo_rx_data_ready_i = 1'b1;
    cfg_slave_en_i = 1'b0;
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err_o);
    end
  endtask

  task automatic test_reserved_mode();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsvd_idle_wait: got busy %b expected 0", busy_o);
    end
    cfg_mode_i = 2'd3;
    cfg_slave_en_i = 1'b1;
    tick();
    checks++;
    if (err_o !== 1'b1 || {en_i2s_o, en_dsp_o, en_pdm_o, busy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL rsvd_err: got err=%b en=%b busy=%b expected 1/000/0",
               err_o, {en_i2s_o, en_dsp_o, en_pdm_o}, busy_o);
    end
    tick();
    tick();
    checks++;
    if (err_o !== 1'b1 || {en_i2s_o, en_dsp_o, en_pdm_o, busy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL rsvd_stay: got err=%b en=%b busy=%b expected 1/000/0",
               err_o, {en_i2s_o, en_dsp_o, en_pdm_o}, busy_o);
    end
    cfg_slave_en_i = 1'b0;
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_clear: got %b expected 0", err_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [8:0] flags;
    cfg_mode_i = 2'd0;
    cfg_slave_en_i = 1'b1;
    fifo_rx_data_ready_i = 1'b1;
    wait_en(3'b100, ok);
    fifo_rx_data_ready_i = 1'b0;
    i2s_data_i = 32'h1111_2222;
    i2s_valid_i = 1'b1;
    tick();
    checks++;
    if (!ok || fifo_rx_data_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: got en_ok=%b valid=%b expected 1/1", ok, fifo_rx_data_valid_o);
    end
    rst_i = 1'b1;
    tick();
    flags = {en_i2s_o, en_dsp_o, en_pdm_o, fifo_rx_data_valid_o, busy_o, err_o,
             i2s_ready_o, dsp_ready_o, pdm_ready_o};
    checks++;
    if (flags !== 9'b0 || fifo_rx_data_o !== 32'h0 || active_mode_o !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got flags %b data %h mode %0d expected 0/0/0",
               flags, fifo_rx_data_o, active_mode_o);
    end
    rst_i = 1'b0;
    cfg_slave_en_i = 1'b0;
    tick();
    tick();
    checks++;
    if (fifo_rx_data_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_beat: got valid=%b busy=%b expected 0/0", fifo_rx_data_valid_o, busy_o);
    end
    i2s_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    cfg_slave_en_i = 1'b0;
    cfg_mode_i = 2'd0;
    cfg_guard_cycles_i = 8'd0;
    i2s_data_i = 32'h0;
    dsp_data_i = 32'h0;
    pdm_data_i = 16'h0;
    i2s_valid_i = 1'b0;
    dsp_valid_i = 1'b0;
    pdm_valid_i = 1'b0;
    fifo_rx_data_ready_i = 1'b0;
    test_reset();
    test_i2s_stream();
    test_pdm_zero_ext();
    test_mode_switch();
    test_drain_timeout();
    test_reserved_mode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
